// File: rtl/bp_be_dcache_pkg.sv
// Shared dcache LCE definitions: sequencer state, tag/stat packet opcodes
// and packet width helpers.
// Packet layouts (MSB to LSB):
//   tag_mem : {opcode[1:0], index, way_id, state[1:0], tag}
//   stat_mem: {opcode[1:0], index, way_id}
package bp_be_dcache_pkg;

    typedef enum logic [1:0] {
        e_reset = 2'd0,
        e_init  = 2'd1,
        e_run   = 2'd2
    } bp_be_dcache_lce_seq_state_e;

    typedef enum logic [1:0] {
        e_dcache_lce_tag_mem_set_clear  = 2'd0,
        e_dcache_lce_tag_mem_invalidate = 2'd1,
        e_dcache_lce_tag_mem_set_tag    = 2'd2
    } bp_be_dcache_lce_tag_mem_opcode_e;

    typedef enum logic [1:0] {
        e_dcache_lce_stat_mem_set_clear   = 2'd0,
        e_dcache_lce_stat_mem_clear_dirty = 2'd1,
        e_dcache_lce_stat_mem_set_lru     = 2'd2
    } bp_be_dcache_lce_stat_mem_opcode_e;

    localparam int lce_opcode_width_lp = 2;
    localparam int lce_coh_state_width_lp = 2;

    // Index/way width that stays legal for a single set or way.
    function automatic int safe_clog2(input int val);
        return (val > 1) ? $clog2(val) : 1;
    endfunction

    function automatic int tag_mem_pkt_width(input int sets, input int ways, input int tag_width);
        return lce_opcode_width_lp + safe_clog2(sets) + safe_clog2(ways)
             + lce_coh_state_width_lp + tag_width;
    endfunction

    function automatic int stat_mem_pkt_width(input int sets, input int ways);
        return lce_opcode_width_lp + safe_clog2(sets) + safe_clog2(ways);
    endfunction

endpackage

// File: rtl/bp_be_dcache_lce_rr_arb.sv
// Round-robin arbiter for the tag_mem port. Once a grant is shown and not
// accepted it is locked until the accepting cycle, so the winner's packet
// stays stable while the consumer stalls.
module bp_be_dcache_lce_rr_arb
    import bp_be_dcache_pkg::*;
#(
    parameter  int num_req_p = 2,
    localparam int ptr_w     = safe_clog2(num_req_p)
) (
    input  logic                 clk_i,
    input  logic                 reset_i,
    input  logic                 en_i,
    input  logic [num_req_p-1:0] v_i,
    input  logic                 ready_i,
    output logic [num_req_p-1:0] grant_o,
    output logic [ptr_w-1:0]     sel_o,
    output logic                 v_o
);

    logic [ptr_w-1:0] r_rr_ptr;
    logic [ptr_w-1:0] r_lock_idx;
    logic             r_lock_v;
    logic [ptr_w-1:0] w_sel;
    logic             w_found;

    // Pick the locked winner, else the lowest valid at or after rr_ptr, wrapping.
    always_comb begin
        w_sel   = r_rr_ptr;
        w_found = 1'b0;
        if (r_lock_v) begin
            w_sel   = r_lock_idx;
            w_found = 1'b1;
        end else begin
            for (int j = 0; j < num_req_p; j++) begin
                if (!w_found && v_i[j] && (j >= int'(r_rr_ptr))) begin
                    w_found = 1'b1;
                    w_sel   = ptr_w'(j);
                end else begin
                    w_found = w_found;
                end
            end
            for (int j = 0; j < num_req_p; j++) begin
                if (!w_found && v_i[j] && (j < int'(r_rr_ptr))) begin
                    w_found = 1'b1;
                    w_sel   = ptr_w'(j);
                end else begin
                    w_found = w_found;
                end
            end
        end
    end

    // One-hot grant decode of the selected requester.
    always_comb begin
        v_o     = en_i & w_found;
        sel_o   = w_sel;
        grant_o = {num_req_p{1'b0}};
        for (int j = 0; j < num_req_p; j++) begin
            grant_o[j] = v_o && (int'(w_sel) == j);
        end
    end

    // Advance the pointer past the winner on accept; lock the winner while stalled.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            r_rr_ptr   <= {ptr_w{1'b0}};
            r_lock_idx <= {ptr_w{1'b0}};
            r_lock_v   <= 1'b0;
        end else if (!en_i) begin
            r_lock_v   <= 1'b0;
        end else if (v_o && ready_i) begin
            r_rr_ptr   <= (w_sel == ptr_w'(num_req_p - 1)) ? {ptr_w{1'b0}} : (w_sel + ptr_w'(1));
            r_lock_v   <= 1'b0;
        end else if (v_o) begin
            r_lock_idx <= w_sel;
            r_lock_v   <= 1'b1;
        end else begin
            r_lock_v   <= 1'b0;
        end
    end

endmodule

// File: rtl/bp_be_dcache_lce_mem_sequencer.sv
// Owns the dcache tag_mem/stat_mem LCE ports: clears every set after reset,
// then arbitrates LCE tag requesters and passes the stat requester through.
// Optional feature macro: BP_BE_DCACHE_LCE_SEQ_FLUSH_EN (flush_i re-walks the sets).
module bp_be_dcache_lce_mem_sequencer
    import bp_be_dcache_pkg::*;
#(
    parameter  int sets_p      = 64,
    parameter  int ways_p      = 8,
    parameter  int tag_width_p = 10,
    parameter  int num_req_p   = 2,
    localparam int idx_w       = safe_clog2(sets_p),
    localparam int way_w       = safe_clog2(ways_p),
    localparam int ptr_w       = safe_clog2(num_req_p),
    localparam int tpw         = tag_mem_pkt_width(sets_p, ways_p, tag_width_p),
    localparam int spw         = stat_mem_pkt_width(sets_p, ways_p)
) (
    input  logic                     clk_i,
    input  logic                     reset_i,
    input  logic [num_req_p*tpw-1:0] req_tag_pkt_i,
    input  logic [num_req_p-1:0]     req_tag_v_i,
    output logic [num_req_p-1:0]     req_tag_yumi_o,
    input  logic [spw-1:0]           req_stat_pkt_i,
    input  logic                     req_stat_v_i,
    output logic                     req_stat_yumi_o,
    output logic [tpw-1:0]           tag_mem_pkt_o,
    output logic                     tag_mem_pkt_v_o,
    input  logic                     tag_mem_pkt_ready_i,
    output logic [spw-1:0]           stat_mem_pkt_o,
    output logic                     stat_mem_pkt_v_o,
    input  logic                     stat_mem_pkt_ready_i,
    input  logic                     flush_i,
    output logic                     init_done_o
);

    localparam int tag_tail_w = way_w + lce_coh_state_width_lp + tag_width_p;

    bp_be_dcache_lce_seq_state_e r_state, w_state_nxt;
    logic [idx_w-1:0]     r_index, w_index_nxt;
    logic                 r_tag_done, w_tag_done_nxt;
    logic                 r_stat_done, w_stat_done_nxt;
    logic                 w_tag_xfer, w_stat_xfer, w_set_done;
    logic                 w_arb_en, w_arb_v;
    logic [num_req_p-1:0] w_arb_grant;
    logic [ptr_w-1:0]     w_arb_sel;

`ifdef BP_BE_DCACHE_LCE_SEQ_FLUSH_EN
    logic r_flush_pend, w_flush_pend_nxt, w_flush_req, w_idle;
    assign w_flush_req = r_flush_pend | flush_i;
    assign w_idle = (~tag_mem_pkt_v_o | tag_mem_pkt_ready_i)
                  & (~stat_mem_pkt_v_o | stat_mem_pkt_ready_i);
`else
    logic w_unused_flush;
    assign w_unused_flush = flush_i;
`endif

    assign w_tag_xfer  = tag_mem_pkt_v_o & tag_mem_pkt_ready_i;
    assign w_stat_xfer = stat_mem_pkt_v_o & stat_mem_pkt_ready_i;
    assign w_set_done  = (r_tag_done | w_tag_xfer) & (r_stat_done | w_stat_xfer);
    assign w_arb_en    = (r_state == e_run);

    bp_be_dcache_lce_rr_arb #(.num_req_p(num_req_p)) u_rr_arb (
        .clk_i   (clk_i),
        .reset_i (reset_i),
        .en_i    (w_arb_en),
        .v_i     (req_tag_v_i),
        .ready_i (tag_mem_pkt_ready_i),
        .grant_o (w_arb_grant),
        .sel_o   (w_arb_sel),
        .v_o     (w_arb_v)
    );

    // Port outputs: set_clear packets while walking, arbitrated traffic in run.
    always_comb begin
        tag_mem_pkt_o    = {tpw{1'b0}};
        tag_mem_pkt_v_o  = 1'b0;
        stat_mem_pkt_o   = {spw{1'b0}};
        stat_mem_pkt_v_o = 1'b0;
        req_tag_yumi_o   = {num_req_p{1'b0}};
        req_stat_yumi_o  = 1'b0;
        init_done_o      = 1'b0;
        if (reset_i) begin
            init_done_o = 1'b0;
        end else begin
            case (r_state)
                e_init: begin
                    tag_mem_pkt_o    = {e_dcache_lce_tag_mem_set_clear, r_index, {tag_tail_w{1'b0}}};
                    tag_mem_pkt_v_o  = ~r_tag_done;
                    stat_mem_pkt_o   = {e_dcache_lce_stat_mem_set_clear, r_index, {way_w{1'b0}}};
                    stat_mem_pkt_v_o = ~r_stat_done;
                end
                e_run: begin
                    init_done_o      = 1'b1;
                    tag_mem_pkt_o    = req_tag_pkt_i[int'(w_arb_sel)*tpw +: tpw];
                    tag_mem_pkt_v_o  = w_arb_v;
                    req_tag_yumi_o   = w_arb_grant & {num_req_p{tag_mem_pkt_ready_i}};
                    stat_mem_pkt_o   = req_stat_pkt_i;
                    stat_mem_pkt_v_o = req_stat_v_i;
                    req_stat_yumi_o  = req_stat_v_i & stat_mem_pkt_ready_i;
                end
                default: begin
                    init_done_o = 1'b0;
                end
            endcase
        end
    end

    // Next state: set walk bookkeeping and run/flush transitions.
    always_comb begin
        w_state_nxt     = r_state;
        w_index_nxt     = r_index;
        w_tag_done_nxt  = r_tag_done;
        w_stat_done_nxt = r_stat_done;
`ifdef BP_BE_DCACHE_LCE_SEQ_FLUSH_EN
        w_flush_pend_nxt = 1'b0;
`endif
        case (r_state)
            e_reset: begin
                w_state_nxt     = e_init;
                w_index_nxt     = {idx_w{1'b0}};
                w_tag_done_nxt  = 1'b0;
                w_stat_done_nxt = 1'b0;
            end
            e_init: begin
                if (w_set_done) begin
                    w_tag_done_nxt  = 1'b0;
                    w_stat_done_nxt = 1'b0;
                    if (r_index == idx_w'(sets_p - 1)) begin
                        w_state_nxt = e_run;
                        w_index_nxt = {idx_w{1'b0}};
                    end else begin
                        w_index_nxt = r_index + idx_w'(1);
                    end
                end else begin
                    w_tag_done_nxt  = r_tag_done | w_tag_xfer;
                    w_stat_done_nxt = r_stat_done | w_stat_xfer;
                end
            end
            e_run: begin
`ifdef BP_BE_DCACHE_LCE_SEQ_FLUSH_EN
                if (w_flush_req && w_idle) begin
                    w_state_nxt      = e_init;
                    w_index_nxt      = {idx_w{1'b0}};
                    w_tag_done_nxt   = 1'b0;
                    w_stat_done_nxt  = 1'b0;
                    w_flush_pend_nxt = 1'b0;
                end else begin
                    w_flush_pend_nxt = w_flush_req;
                end
`else
                w_state_nxt = e_run;
`endif
            end
            default: begin
                w_state_nxt = e_reset;
            end
        endcase
    end

    // State and walk registers with synchronous reset.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            r_state     <= e_reset;
            r_index     <= {idx_w{1'b0}};
            r_tag_done  <= 1'b0;
            r_stat_done <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_index     <= w_index_nxt;
            r_tag_done  <= w_tag_done_nxt;
            r_stat_done <= w_stat_done_nxt;
        end
    end

`ifdef BP_BE_DCACHE_LCE_SEQ_FLUSH_EN
    // Pending flush holds until both ports are free of outstanding handshakes.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            r_flush_pend <= 1'b0;
        end else begin
            r_flush_pend <= w_flush_pend_nxt;
        end
    end
`endif

endmodule

// File: tb/tb_bp_be_dcache_lce_mem_sequencer.sv
// Directed bench: sets_p=4, ways_p=8, tag_width_p=10, num_req_p=2 (main DUT)
// plus a num_req_p=1 instance. Tag packet is 19 bits, stat packet 7 bits.
module tb_bp_be_dcache_lce_mem_sequencer;

    localparam logic [18:0] P0  = 19'h2A5A5;
    localparam logic [18:0] P1  = 19'h51234;
    localparam logic [18:0] D1P = 19'h3C3C3;
    localparam logic [6:0]  SP  = 7'h5B;

    logic        clk = 1'b0;
    logic        reset;
    logic [37:0] req_tag_pkt;
    logic [1:0]  req_tag_v;
    logic [1:0]  req_tag_yumi;
    logic [6:0]  req_stat_pkt;
    logic        req_stat_v, req_stat_yumi;
    logic [18:0] tag_pkt;
    logic        tag_v, tag_ready;
    logic [6:0]  stat_pkt;
    logic        stat_v, stat_ready;
    logic        flush, init_done;

    logic [18:0] d1_pkt_i;
    logic [0:0]  d1_v_i, d1_yumi;
    logic [6:0]  d1_stat_pkt_i, d1_stat_pkt;
    logic        d1_stat_v_i, d1_stat_yumi, d1_stat_v, d1_stat_ready;
    logic [18:0] d1_tag_pkt;
    logic        d1_tag_v, d1_ready, d1_flush, d1_init_done;

    int n_cmp = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    bp_be_dcache_lce_mem_sequencer #(.sets_p(4), .ways_p(8), .tag_width_p(10), .num_req_p(2)) u_dut (
        .clk_i(clk), .reset_i(reset),
        .req_tag_pkt_i(req_tag_pkt), .req_tag_v_i(req_tag_v), .req_tag_yumi_o(req_tag_yumi),
        .req_stat_pkt_i(req_stat_pkt), .req_stat_v_i(req_stat_v), .req_stat_yumi_o(req_stat_yumi),
        .tag_mem_pkt_o(tag_pkt), .tag_mem_pkt_v_o(tag_v), .tag_mem_pkt_ready_i(tag_ready),
        .stat_mem_pkt_o(stat_pkt), .stat_mem_pkt_v_o(stat_v), .stat_mem_pkt_ready_i(stat_ready),
        .flush_i(flush), .init_done_o(init_done)
    );

    bp_be_dcache_lce_mem_sequencer #(.sets_p(4), .ways_p(8), .tag_width_p(10), .num_req_p(1)) u_dut1 (
        .clk_i(clk), .reset_i(reset),
        .req_tag_pkt_i(d1_pkt_i), .req_tag_v_i(d1_v_i), .req_tag_yumi_o(d1_yumi),
        .req_stat_pkt_i(d1_stat_pkt_i), .req_stat_v_i(d1_stat_v_i), .req_stat_yumi_o(d1_stat_yumi),
        .tag_mem_pkt_o(d1_tag_pkt), .tag_mem_pkt_v_o(d1_tag_v), .tag_mem_pkt_ready_i(d1_ready),
        .stat_mem_pkt_o(d1_stat_pkt), .stat_mem_pkt_v_o(d1_stat_v), .stat_mem_pkt_ready_i(d1_stat_ready),
        .flush_i(d1_flush), .init_done_o(d1_init_done)
    );

    typedef struct {
        logic [1:0]  tv;
        logic        trdy;
        logic        sv;
        logic        srdy;
        logic        e_tv;
        logic [18:0] e_tpkt;
        logic [1:0]  e_yumi;
        logic        e_sv;
        logic [6:0]  e_spkt;
        logic        e_syumi;
        logic        e_done;
    } vec_t;

    vec_t vecs [16];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        req_tag_v = 2'b00;
        req_stat_v = 1'b0;
        flush = 1'b0;
        tag_ready = 1'b1;
        stat_ready = 1'b1;
        cyc();
        cyc();
        reset = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        req_tag_pkt = {P1, P0};
        req_stat_pkt = SP;
        d1_pkt_i = D1P;
        d1_v_i = 1'b0;
        d1_stat_pkt_i = 7'h00;
        d1_stat_v_i = 1'b0;
        d1_stat_ready = 1'b1;
        d1_ready = 1'b1;
        d1_flush = 1'b0;

        // Walk of 4 sets then round-robin traffic; requesters valid during the walk must see no yumi.
        vecs[0]  = '{2'b11, 1'b1, 1'b1, 1'b1, 1'b0, 19'h00000, 2'b00, 1'b0, 7'h00, 1'b0, 1'b0};
        vecs[1]  = '{2'b11, 1'b1, 1'b1, 1'b1, 1'b1, 19'h00000, 2'b00, 1'b1, 7'h00, 1'b0, 1'b0};
        vecs[2]  = '{2'b11, 1'b1, 1'b1, 1'b1, 1'b1, 19'h08000, 2'b00, 1'b1, 7'h08, 1'b0, 1'b0};
        vecs[3]  = '{2'b11, 1'b1, 1'b1, 1'b1, 1'b1, 19'h10000, 2'b00, 1'b1, 7'h10, 1'b0, 1'b0};
        vecs[4]  = '{2'b11, 1'b1, 1'b1, 1'b1, 1'b1, 19'h18000, 2'b00, 1'b1, 7'h18, 1'b0, 1'b0};
        vecs[5]  = '{2'b00, 1'b1, 1'b0, 1'b1, 1'b0, 19'h00000, 2'b00, 1'b0, 7'h00, 1'b0, 1'b1};
        vecs[6]  = '{2'b11, 1'b1, 1'b1, 1'b1, 1'b1, P0,        2'b01, 1'b1, SP,    1'b1, 1'b1};
        vecs[7]  = '{2'b11, 1'b1, 1'b0, 1'b1, 1'b1, P1,        2'b10, 1'b0, 7'h00, 1'b0, 1'b1};
        vecs[8]  = '{2'b11, 1'b1, 1'b0, 1'b1, 1'b1, P0,        2'b01, 1'b0, 7'h00, 1'b0, 1'b1};
        vecs[9]  = '{2'b11, 1'b1, 1'b0, 1'b1, 1'b1, P1,        2'b10, 1'b0, 7'h00, 1'b0, 1'b1};
        vecs[10] = '{2'b10, 1'b0, 1'b1, 1'b0, 1'b1, P1,        2'b00, 1'b1, SP,    1'b0, 1'b1};
        vecs[11] = '{2'b11, 1'b0, 1'b1, 1'b0, 1'b1, P1,        2'b00, 1'b1, SP,    1'b0, 1'b1};
        vecs[12] = '{2'b11, 1'b1, 1'b1, 1'b1, 1'b1, P1,        2'b10, 1'b1, SP,    1'b1, 1'b1};
        vecs[13] = '{2'b11, 1'b1, 1'b0, 1'b1, 1'b1, P0,        2'b01, 1'b0, 7'h00, 1'b0, 1'b1};
        vecs[14] = '{2'b01, 1'b1, 1'b0, 1'b1, 1'b1, P0,        2'b01, 1'b0, 7'h00, 1'b0, 1'b1};
        vecs[15] = '{2'b00, 1'b1, 1'b0, 1'b1, 1'b0, 19'h00000, 2'b00, 1'b0, 7'h00, 1'b0, 1'b1};

        // Reset state, with requesters asserting to prove nothing leaks through.
        reset = 1'b1;
        flush = 1'b0;
        tag_ready = 1'b1;
        stat_ready = 1'b1;
        req_tag_v = 2'b11;
        req_stat_v = 1'b1;
        cyc();
        cyc();
        @(negedge clk);
        chk("rst tag_v", 32'(tag_v), 32'd0);
        chk("rst stat_v", 32'(stat_v), 32'd0);
        chk("rst tag_pkt", 32'(tag_pkt), 32'd0);
        chk("rst stat_pkt", 32'(stat_pkt), 32'd0);
        chk("rst yumi", 32'(req_tag_yumi), 32'd0);
        chk("rst stat_yumi", 32'(req_stat_yumi), 32'd0);
        chk("rst init_done", 32'(init_done), 32'd0);
        cyc();
        reset = 1'b0;

        for (int i = 0; i < 16; i++) begin
            req_tag_v  = vecs[i].tv;
            tag_ready  = vecs[i].trdy;
            req_stat_v = vecs[i].sv;
            stat_ready = vecs[i].srdy;
            @(negedge clk);
            chk($sformatf("v%0d tag_v", i), 32'(tag_v), 32'(vecs[i].e_tv));
            if (vecs[i].e_tv) chk($sformatf("v%0d tag_pkt", i), 32'(tag_pkt), 32'(vecs[i].e_tpkt));
            chk($sformatf("v%0d yumi", i), 32'(req_tag_yumi), 32'(vecs[i].e_yumi));
            chk($sformatf("v%0d stat_v", i), 32'(stat_v), 32'(vecs[i].e_sv));
            if (vecs[i].e_sv) chk($sformatf("v%0d stat_pkt", i), 32'(stat_pkt), 32'(vecs[i].e_spkt));
            chk($sformatf("v%0d stat_yumi", i), 32'(req_stat_yumi), 32'(vecs[i].e_syumi));
            chk($sformatf("v%0d init_done", i), 32'(init_done), 32'(vecs[i].e_done));
            cyc();
        end

        // Stat port stalls for 3 cycles at set 1: tag goes once, stat held, then set 2.
        do_reset();
        cyc();
        cyc();
        stat_ready = 1'b0;
        @(negedge clk);
        chk("stall1 tag_v", 32'(tag_v), 32'd1);
        chk("stall1 tag_pkt", 32'(tag_pkt), 32'h08000);
        chk("stall1 stat_v", 32'(stat_v), 32'd1);
        cyc();
        @(negedge clk);
        chk("stall2 tag_v", 32'(tag_v), 32'd0);
        chk("stall2 stat_v", 32'(stat_v), 32'd1);
        chk("stall2 stat_pkt", 32'(stat_pkt), 32'h08);
        cyc();
        @(negedge clk);
        chk("stall3 tag_v", 32'(tag_v), 32'd0);
        chk("stall3 stat_pkt", 32'(stat_pkt), 32'h08);
        cyc();
        stat_ready = 1'b1;
        @(negedge clk);
        chk("stall4 tag_v", 32'(tag_v), 32'd0);
        chk("stall4 stat_v", 32'(stat_v), 32'd1);
        chk("stall4 stat_pkt", 32'(stat_pkt), 32'h08);
        cyc();
        @(negedge clk);
        chk("idx2 tag_v", 32'(tag_v), 32'd1);
        chk("idx2 stat_v", 32'(stat_v), 32'd1);
        chk("idx2 tag_pkt", 32'(tag_pkt), 32'h10000);

        // Reset while set 2 is on the ports: outputs drop, walk restarts at set 0.
        reset = 1'b1;
        cyc();
        @(negedge clk);
        chk("midrst tag_v", 32'(tag_v), 32'd0);
        chk("midrst stat_v", 32'(stat_v), 32'd0);
        chk("midrst init_done", 32'(init_done), 32'd0);
        reset = 1'b0;
        cyc();
        @(negedge clk);
        chk("rewalk0 tag_v", 32'(tag_v), 32'd1);
        chk("rewalk0 tag_pkt", 32'(tag_pkt), 32'h00000);
        chk("rewalk0 stat_pkt", 32'(stat_pkt), 32'h00);
        cyc();
        @(negedge clk);
        chk("rewalk1 tag_pkt", 32'(tag_pkt), 32'h08000);
        cyc();
        cyc();
        @(negedge clk);
        chk("rewalk3 tag_pkt", 32'(tag_pkt), 32'h18000);
        chk("rewalk3 init_done", 32'(init_done), 32'd0);
        cyc();
        @(negedge clk);
        chk("rewalk run init_done", 32'(init_done), 32'd1);
        chk("rewalk run tag_v", 32'(tag_v), 32'd0);

        // Flush request while running.
        flush = 1'b1;
        @(negedge clk);
        chk("flush cyc init_done", 32'(init_done), 32'd1);
        cyc();
        flush = 1'b0;
`ifdef BP_BE_DCACHE_LCE_SEQ_FLUSH_EN
        @(negedge clk);
        chk("flush idx0 init_done", 32'(init_done), 32'd0);
        chk("flush idx0 tag_v", 32'(tag_v), 32'd1);
        chk("flush idx0 tag_pkt", 32'(tag_pkt), 32'h00000);
        cyc();
        cyc();
        cyc();
        @(negedge clk);
        chk("flush idx3 tag_pkt", 32'(tag_pkt), 32'h18000);
        chk("flush idx3 stat_pkt", 32'(stat_pkt), 32'h18);
        cyc();
        @(negedge clk);
        chk("flush done init_done", 32'(init_done), 32'd1);
`else
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk($sformatf("noflush%0d init_done", i), 32'(init_done), 32'd1);
            chk($sformatf("noflush%0d tag_v", i), 32'(tag_v), 32'd0);
            cyc();
        end
`endif
        req_tag_v = 2'b10;
        @(negedge clk);
        chk("post flush yumi1", 32'(req_tag_yumi), 32'b10);
        chk("post flush pkt1", 32'(tag_pkt), 32'(P1));
        cyc();
        req_tag_v = 2'b01;
        @(negedge clk);
        chk("post flush yumi0", 32'(req_tag_yumi), 32'b01);
        chk("post flush pkt0", 32'(tag_pkt), 32'(P0));
        cyc();
        req_tag_v = 2'b00;

        // Single requester instance: granted every valid cycle, held while stalled.
        @(negedge clk);
        chk("d1 init_done", 32'(d1_init_done), 32'd1);
        d1_v_i = 1'b1;
        d1_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk($sformatf("d1 grant%0d", i), 32'(d1_yumi), 32'd1);
            chk($sformatf("d1 pkt%0d", i), 32'(d1_tag_pkt), 32'(D1P));
            cyc();
        end
        d1_v_i = 1'b0;
        @(negedge clk);
        chk("d1 idle tag_v", 32'(d1_tag_v), 32'd0);
        chk("d1 idle yumi", 32'(d1_yumi), 32'd0);
        cyc();
        d1_v_i = 1'b1;
        d1_ready = 1'b0;
        @(negedge clk);
        chk("d1 stall tag_v", 32'(d1_tag_v), 32'd1);
        chk("d1 stall yumi", 32'(d1_yumi), 32'd0);
        chk("d1 stall pkt", 32'(d1_tag_pkt), 32'(D1P));
        cyc();
        d1_ready = 1'b1;
        @(negedge clk);
        chk("d1 release yumi", 32'(d1_yumi), 32'd1);
        cyc();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
